stripe_feeder: RTL
==================

STRIPE_FEEDER -- requirements
Module: stripe_feeder

Interface
REQ-001 Parameters: SEQ_LEN = 1024, query/reference length in bases; PE_NUM = 64, PEs per stripe; GAP_CYCLES = 5, idle cycles before each stripe; all taken from the shared package.
REQ-002 i_clk  in  1  the single clock; all logic rises on it.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_job_start  in  1  one-cycle pulse that starts an alignment job; honoured only in IDLE.
REQ-005 o_a_addr  out  10  read address into the A-sequence memory (one 2-bit base per word).
REQ-006 i_a_data  in  2  A base, valid exactly 1 cycle after o_a_addr.
REQ-007 o_b_addr  out  4  stripe address into the B memory (64 bases per word).
REQ-008 i_b_data  in  128  B word, valid 1 cycle after o_b_addr; base k sits at bits [2k+1:2k].
REQ-009 o_pe_start  out  1  marks o_pe_a as a valid streamed base; feeds the PE array's i_start.
REQ-010 o_pe_a  out  2  streamed A base; feeds the PE array's i_A.
REQ-011 o_pe_b  out  128  current stripe's B bases, held stable for the whole stripe; feeds i_B.
REQ-012 i_stripe_end  in  1  PE-array stripe-complete flag.
REQ-013 i_start_position  in  10  PE-array A index at which the stripe ended.
REQ-014 i_max_score_stripe  in  14  PE-array best score for the stripe.
REQ-015 o_busy  out  1  high while a job is in progress, i.e. whenever the FSM is not in IDLE.
REQ-016 o_done  out  1  one-cycle pulse when a job completes.
REQ-017 o_max_score  out  14  best score across all stripes of the job.
REQ-018 o_best_stripe  out  4  index of the stripe that produced o_max_score.

Function
REQ-019 FSM states: IDLE, B_REQ, B_CAP, GAP, STREAM, WAIT_END, FINISH.
REQ-020 IDLE -> B_REQ on i_job_start; the same edge clears o_max_score and o_best_stripe and sets stripe index = 0 and A index = 0.
REQ-021 B_REQ drives o_b_addr = stripe index and goes to B_CAP; B_CAP registers i_b_data into o_pe_b and goes to GAP.
REQ-022 GAP holds o_pe_start low for exactly GAP_CYCLES cycles, then goes to STREAM.
REQ-023 STREAM issues o_a_addr = A index and increments the index each cycle; the base returned one cycle later drives o_pe_a, with o_pe_start = 1 in that same cycle.
REQ-024 Streaming latency: the first o_pe_start pulse of a stripe appears 1 cycle after the first o_a_addr.
REQ-025 Once address SEQ_LEN-1 has been issued without i_stripe_end, STREAM -> WAIT_END; o_pe_start drops after the last in-flight base.
REQ-026 When i_stripe_end = 1 in STREAM or WAIT_END:
- issue no further addresses;
- drive o_pe_start = 0 from the next cycle and discard the in-flight base;
- set the resume A index = i_start_position + 1;
- if i_max_score_stripe > o_max_score (strict), update o_max_score and o_best_stripe;
- increment the stripe index.
REQ-027 After the stripe-end update: go to FINISH if the stripe index has wrapped past 15 or the resume index is >= SEQ_LEN; otherwise go to B_REQ.
REQ-028 If i_stripe_end coincides with issue of address SEQ_LEN-1, the stripe-end handling wins.
REQ-029 i_stripe_end in IDLE, B_REQ, B_CAP, GAP or FINISH is ignored.
REQ-030 FINISH pulses o_done for 1 cycle, then goes to IDLE; o_max_score and o_best_stripe hold until the next i_job_start.
REQ-031 i_job_start while o_busy = 1 is ignored.
REQ-032 Resume-index arithmetic is 11 bits wide so that i_start_position = 1023 does not wrap.

Reset
REQ-033 i_rst_n low forces FSM = IDLE, and stripe index, A index, o_a_addr, o_b_addr, o_pe_a, o_pe_b, o_max_score and o_best_stripe all = 0.
REQ-034 i_rst_n low forces o_pe_start, o_busy and o_done to 0.
REQ-035 Reset mid-job aborts the job immediately; no o_done pulse is emitted.

Structure
REQ-036 The shared package holds SEQ_LEN, PE_NUM, GAP_CYCLES, the base width (2), the score width (14) and the FSM state enum.
REQ-037 One sub-module, stripe_max_tracker, holds the compare and register logic for o_max_score and o_best_stripe.

Verification
REQ-038 Job start with a PE model asserting i_stripe_end at stream cycle 100, i_start_position = 99 -> stripe 1 begins streaming at A address 100, after 5 gap cycles.
REQ-039 Stripe scores 40, 75, 75, 12 over 4 stripes -> o_max_score = 75, o_best_stripe = 1 (ties do not update).
REQ-040 A index exhausted without i_stripe_end -> WAIT_END; o_pe_start low after base 1023; i_stripe_end then advances the stripe.
REQ-041 i_start_position = 1023 -> FINISH, o_done pulses once, o_busy falls the next cycle.
REQ-042 i_rst_n pulsed low during STREAM -> all outputs 0 and o_done never pulses; a fresh i_job_start runs normally.
REQ-043 i_job_start pulsed during STREAM -> no effect on addresses or scores.

Source files
------------

// File: rtl/stripe_feeder_pkg.sv
// Shared sizing and FSM encoding for the stripe feeder: A/B memory geometry,
// score width and the feeder's state machine states.
package stripe_feeder_pkg;

  localparam int unsigned SEQ_LEN    = 1024;
  localparam int unsigned PE_NUM     = 64;
  localparam int unsigned GAP_CYCLES = 5;
  localparam int unsigned BASE_W     = 2;
  localparam int unsigned SCORE_W    = 14;

  localparam int unsigned A_ADDR_W   = $clog2(SEQ_LEN);
  localparam int unsigned STRIPE_NUM = SEQ_LEN / PE_NUM;
  localparam int unsigned B_ADDR_W   = $clog2(STRIPE_NUM);
  localparam int unsigned B_WORD_W   = PE_NUM * BASE_W;
  localparam int unsigned GAP_W      = $clog2(GAP_CYCLES);
  // One extra bit so that a resume index of SEQ_LEN can be represented.
  localparam int unsigned POS_W      = A_ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_B_REQ,
    S_B_CAP,
    S_GAP,
    S_STREAM,
    S_WAIT_END,
    S_FINISH
  } state_t;

endpackage

// File: rtl/stripe_max_tracker.sv
// Keeps the best stripe score of the current job and the stripe that produced it.
module stripe_max_tracker
  import stripe_feeder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                sample,
  input  logic [SCORE_W-1:0]  score,
  input  logic [B_ADDR_W-1:0] stripe,
  output logic [SCORE_W-1:0]  max_score,
  output logic [B_ADDR_W-1:0] best_stripe
);

  // Strict compare: an equal score keeps the earlier stripe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_score   <= '0;
      best_stripe <= '0;
    end else if (clear) begin
      max_score   <= '0;
      best_stripe <= '0;
    end else if (sample && (score > max_score)) begin
      max_score   <= score;
      best_stripe <= stripe;
    end
  end

endmodule

// File: rtl/stripe_feeder.sv
// Feeds a systolic PE array stripe by stripe: loads a B word, waits a gap,
// streams A bases until the array reports stripe end, and tracks the best score.
module stripe_feeder
  import stripe_feeder_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_job_start,
  output logic [A_ADDR_W-1:0] o_a_addr,
  input  logic [BASE_W-1:0]   i_a_data,
  output logic [B_ADDR_W-1:0] o_b_addr,
  input  logic [B_WORD_W-1:0] i_b_data,
  output logic                o_pe_start,
  output logic [BASE_W-1:0]   o_pe_a,
  output logic [B_WORD_W-1:0] o_pe_b,
  input  logic                i_stripe_end,
  input  logic [A_ADDR_W-1:0] i_start_position,
  input  logic [SCORE_W-1:0]  i_max_score_stripe,
  output logic                o_busy,
  output logic                o_done,
  output logic [SCORE_W-1:0]  o_max_score,
  output logic [B_ADDR_W-1:0] o_best_stripe
);

  state_t                state, state_n;
  logic [A_ADDR_W-1:0]   a_idx, a_idx_n;
  logic [B_ADDR_W-1:0]   stripe_idx, stripe_n;
  logic [GAP_W-1:0]      gap_cnt, gap_n;
  logic                  pe_start_n;
  logic [B_WORD_W-1:0]   pe_b_n;
  logic                  clear_max, sample_max;
  logic [POS_W-1:0]      resume;
  logic                  a_last, stripe_last;

  assign resume      = POS_W'(i_start_position) + POS_W'(1);
  assign a_last      = (a_idx == A_ADDR_W'(SEQ_LEN - 1));
  assign stripe_last = (stripe_idx == B_ADDR_W'(STRIPE_NUM - 1));

  assign o_a_addr = a_idx;
  assign o_b_addr = stripe_idx;
  // The A memory returns a base one cycle after its address, which is exactly
  // when o_pe_start is high, so the base is forwarded and masked by that flag.
  assign o_pe_a   = o_pe_start ? i_a_data : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      a_idx      <= '0;
      stripe_idx <= '0;
      gap_cnt    <= '0;
      o_pe_start <= 1'b0;
      o_pe_b     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_n;
      a_idx      <= a_idx_n;
      stripe_idx <= stripe_n;
      gap_cnt    <= gap_n;
      o_pe_start <= pe_start_n;
      o_pe_b     <= pe_b_n;
      o_busy     <= (state_n != S_IDLE);
      o_done     <= (state_n == S_FINISH);
    end
  end

  always_comb begin
    state_n    = state;
    a_idx_n    = a_idx;
    stripe_n   = stripe_idx;
    gap_n      = gap_cnt;
    pe_start_n = 1'b0;
    pe_b_n     = o_pe_b;
    clear_max  = 1'b0;
    sample_max = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_job_start) begin
          state_n   = S_B_REQ;
          a_idx_n   = '0;
          stripe_n  = '0;
          clear_max = 1'b1;
        end
      end
      S_B_REQ: state_n = S_B_CAP;
      S_B_CAP: begin
        pe_b_n  = i_b_data;
        gap_n   = '0;
        state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_n = S_STREAM;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      S_STREAM, S_WAIT_END: begin
        // Stripe end takes priority over issuing the next (or last) address.
        if (i_stripe_end) begin
          sample_max = 1'b1;
          stripe_n   = stripe_idx + B_ADDR_W'(1);
          a_idx_n    = A_ADDR_W'(resume);
          if (stripe_last || (resume >= POS_W'(SEQ_LEN))) begin
            state_n = S_FINISH;
          end else begin
            state_n = S_B_REQ;
          end
        end else if (state == S_STREAM) begin
          pe_start_n = 1'b1;
          if (a_last) begin
            state_n = S_WAIT_END;
          end else begin
            a_idx_n = a_idx + A_ADDR_W'(1);
          end
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  stripe_max_tracker u_max (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .clear       (clear_max),
    .sample      (sample_max),
    .score       (i_max_score_stripe),
    .stripe      (stripe_idx),
    .max_score   (o_max_score),
    .best_stripe (o_best_stripe)
  );

endmodule
